pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Sequences the T20 PLL and the system reset. Drives the PLL RSTN pin and waits for a stable LOCKED.
//  Releases SYS_RSTN to the RISC-V core only after lock has held steady; restarts the whole sequence on lock loss.
//  Sits at top level between the PLL instance and the core, clocked by the 12 MHz input clock.
// PARAMETERS
//  PLL_RST_CYCLES     12     cycles PLL_RSTN is held low per reset pulse (1 us @ 12 MHz)
//  LOCK_STABLE_CYCLES 1024   consecutive synchronized-lock cycles required before SYS_RSTN release
//  LOCK_TIMEOUT       12000  max cycles in WAIT_LOCK before retry (macro-gated, see CONFIGURATION)
// PORTS
//  CLK                in   1  reference clock (pre-PLL input clock)
//  RESETN             in   1  asynchronous, active-low reset
//  PLL_LOCKED         in   1  PLL lock, asynchronous to CLK; 2-flop synchronized internally
//  SOFT_RST_REQ       in   1  single-cycle request (CLK domain) to rerun the full sequence
//  PLL_RSTN           out  1  PLL reset, active low, registered
//  SYS_RSTN           out  1  system reset, active low, registered; core domain re-synchronizes it
//  SEQ_STATE          out  2  current FSM state encoding
//  RELOCK_CNT         out  8  lock-loss events seen in RUN, saturates at 255
//  LOCK_TIMEOUT_FLAG  out  1  sticky: a WAIT_LOCK timeout occurred since last RUN entry
// BEHAVIOUR
//  Reset (RESETN=0, async): PLL_RSTN=0, SYS_RSTN=0, SEQ_STATE=PLL_RST, RELOCK_CNT=0,
//   LOCK_TIMEOUT_FLAG=0, counters=0, sync flops=0.
//  lock_s = PLL_LOCKED after 2 CLK edges.
//  States (encoding): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
//  - PLL_RST: PLL_RSTN=0, SYS_RSTN=0. Leave for WAIT_LOCK after exactly PLL_RST_CYCLES cycles in state.
//  - WAIT_LOCK: PLL_RSTN=1, SYS_RSTN=0. lock_s=1 -> STABLE, count cleared.
//  - STABLE: count consecutive cycles with lock_s=1.
//    - lock_s=0 -> WAIT_LOCK, count cleared.
//    - count reaches LOCK_STABLE_CYCLES -> RUN.
//  - RUN: SYS_RSTN=1. lock_s=0 -> PLL_RST, RELOCK_CNT++ (saturating), SYS_RSTN=0 on the same edge.
//  Outputs are registered from the next state: SYS_RSTN changes on the edge the FSM enters or leaves RUN.
//  Entering RUN clears LOCK_TIMEOUT_FLAG.
//  SOFT_RST_REQ=1 in any state: -> PLL_RST on the next edge.
//   Highest priority over lock events; RELOCK_CNT is not incremented. RELOCK_CNT is cleared only by RESETN.
//  Counters sized by $clog2(max param)+1 and never wrap; every state entry clears the count.
// CONFIGURATION
//  PLL_SEQ_LOCK_TIMEOUT_EN defined:
//   - WAIT_LOCK goes to PLL_RST after LOCK_TIMEOUT cycles without lock_s and sets LOCK_TIMEOUT_FLAG.
//   - Retries continue indefinitely.
//  Not defined:
//   - WAIT_LOCK waits forever; LOCK_TIMEOUT unused; LOCK_TIMEOUT_FLAG tied 0.
// STRUCTURE
//  Package pll_seq_pkg:
//   - state typedef seq_state_t with the encodings above
//   - RELOCK_CNT_MAX=255
//   - cnt_width() function
//  Sub-module sync_2ff: 2-flop synchronizer with async active-low reset, used for PLL_LOCKED.
//  FSM, counters and output registers live in the top.
// TESTING (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=20)
//  1 Normal bring-up.
//    Stimulus: release RESETN; PLL_LOCKED rises 10 cycles later.
//    Response: PLL_RSTN rises 4 cycles after reset release; SYS_RSTN rises 11 cycles after PLL_LOCKED
//    (2 sync + 1 detect + 8 stable); SEQ_STATE=3.
//  2 Lock glitch in STABLE.
//    Stimulus: PLL_LOCKED low for 3 cycles after 5 stable cycles.
//    Response: FSM returns to WAIT_LOCK; SYS_RSTN stays 0; a full 8-cycle stable run is required again.
//  3 Lock loss in RUN.
//    Stimulus: PLL_LOCKED falls.
//    Response: SYS_RSTN=0 and PLL_RSTN=0 3 cycles later; PLL_RSTN low for 4 cycles; RELOCK_CNT=1.
//    Repeating the loss 300 times leaves RELOCK_CNT=255.
//  4 Timeout.
//    Stimulus: PLL_LOCKED held 0.
//    Response with macro: PLL_RSTN low 4 cycles, high 20 cycles, repeating; LOCK_TIMEOUT_FLAG=1.
//    Response without macro: PLL_RSTN stays 1 forever; flag stays 0.
//  5 Soft reset versus lock loss.
//    Stimulus: in RUN, SOFT_RST_REQ and PLL_LOCKED fall in the same cycle.
//    Response: PLL_RST entered; RELOCK_CNT unchanged; full sequence reruns.
//  6 Reset mid-operation.
//    Stimulus: RESETN asserted mid-STABLE (async, between edges).
//    Response: PLL_RSTN=0, SYS_RSTN=0, RELOCK_CNT=0 immediately; clean bring-up after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
//==============================================================================
// Module  : pll_seq_pkg
// Brief   : Shared state encoding and sizing helpers for the PLL reset sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    localparam logic [7:0] RELOCK_CNT_MAX = 8'd255;

    // One spare bit above the largest terminal count so the counter can never wrap.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_reset_sequencer_sync_2ff.sv
//==============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer with asynchronous active-low reset.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
//==============================================================================
// Module  : pll_reset_sequencer
// Brief   : Sequences PLL reset, waits for stable lock, then releases the system
//           reset; optional WAIT_LOCK timeout via PLL_SEQ_LOCK_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES     = 12,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 12000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       soft_rst_req_i,
    output logic       pll_rstn_o,
    output logic       sys_rstn_o,
    output logic [1:0] seq_state_o,
    output logic [7:0] relock_cnt_o,
    output logic       lock_timeout_flag_o
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = cnt_width(MAX_ALL);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
`endif

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       relock_q, relock_d;
    logic             pll_rstn_q;
    logic             sys_rstn_q;
    logic             lock_s;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    logic             flag_q, flag_d;
`endif

    sync_2ff u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_locked_i),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        relock_d = relock_q;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
        flag_d   = flag_q;
`endif
        unique case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    flag_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
                    flag_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                    if (relock_q != RELOCK_CNT_MAX) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Soft reset overrides any lock event decided above in the same cycle.
        if (soft_rst_req_i) begin
            state_d  = ST_PLL_RST;
            cnt_d    = '0;
            relock_d = relock_q;
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
            flag_d   = flag_q;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            relock_q   <= '0;
            pll_rstn_q <= 1'b0;
            sys_rstn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            relock_q   <= relock_d;
            pll_rstn_q <= (state_d != ST_PLL_RST);
            sys_rstn_q <= (state_d == ST_RUN);
        end
    end

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign lock_timeout_flag_o = flag_q;
`else
    assign lock_timeout_flag_o = 1'b0;
`endif

    assign pll_rstn_o   = pll_rstn_q;
    assign sys_rstn_o   = sys_rstn_q;
    assign seq_state_o  = state_q;
    assign relock_cnt_o = relock_q;

endmodule

`default_nettype wire
